// File: rtl/wb_commit_pkg.sv
// Shared types for the dual-issue writeback/commit stage: register-file widths,
// the long-latency FIFO entry layout and the drain FSM state encoding.
package wb_commit_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } lq_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_STARVE = 2'd2
    } lq_state_e;

endpackage

// File: rtl/wb_commit_if.sv
// Pipe results, long-latency push channel and 2W register-file write ports.
// WB_COMMIT_TRACE_EN adds the pc/inst inputs and the difftest commit outputs.
interface wb_commit_if;
    import wb_commit_pkg::*;

    logic              flush;
    logic              ex0_valid;
    logic              ex0_we;
    logic [ADDR_W-1:0] ex0_waddr;
    logic [DATA_W-1:0] ex0_wdata;
    logic              ex1_valid;
    logic              ex1_we;
    logic [ADDR_W-1:0] ex1_waddr;
    logic [DATA_W-1:0] ex1_wdata;
    logic              lq_valid;
    logic [ADDR_W-1:0] lq_waddr;
    logic [DATA_W-1:0] lq_wdata;
    logic              lq_ready;
    logic              lq_stall_req;
    logic              we1;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;
    logic              we2;
    logic [ADDR_W-1:0] waddr2;
    logic [DATA_W-1:0] wdata2;
`ifdef WB_COMMIT_TRACE_EN
    logic [31:0]       ex0_pc;
    logic [31:0]       ex0_inst;
    logic [31:0]       ex1_pc;
    logic [31:0]       ex1_inst;
    logic              cmt1_valid;
    logic [31:0]       cmt1_pc;
    logic [31:0]       cmt1_inst;
    logic              cmt2_valid;
    logic [31:0]       cmt2_pc;
    logic [31:0]       cmt2_inst;
`endif

    modport master (
        output flush, ex0_valid, ex0_we, ex0_waddr, ex0_wdata,
        output ex1_valid, ex1_we, ex1_waddr, ex1_wdata,
        output lq_valid, lq_waddr, lq_wdata,
        input  lq_ready, lq_stall_req,
        input  we1, waddr1, wdata1, we2, waddr2, wdata2
`ifdef WB_COMMIT_TRACE_EN
        , output ex0_pc, ex0_inst, ex1_pc, ex1_inst
        , input  cmt1_valid, cmt1_pc, cmt1_inst, cmt2_valid, cmt2_pc, cmt2_inst
`endif
    );

    modport slave (
        input  flush, ex0_valid, ex0_we, ex0_waddr, ex0_wdata,
        input  ex1_valid, ex1_we, ex1_waddr, ex1_wdata,
        input  lq_valid, lq_waddr, lq_wdata,
        output lq_ready, lq_stall_req,
        output we1, waddr1, wdata1, we2, waddr2, wdata2
`ifdef WB_COMMIT_TRACE_EN
        , input  ex0_pc, ex0_inst, ex1_pc, ex1_inst
        , output cmt1_valid, cmt1_pc, cmt1_inst, cmt2_valid, cmt2_pc, cmt2_inst
`endif
    );

endinterface

// File: rtl/wb_lq_fifo.sv
// Long-latency result FIFO: one push and up to two pops per cycle, exposing
// the two oldest entries so the commit stage can fill both write ports.
module wb_lq_fifo
    import wb_commit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     i_push,
    input  lq_entry_t                i_push_data,
    input  logic [1:0]               i_pop_n,
    output lq_entry_t                o_head0,
    output lq_entry_t                o_head1,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);

    lq_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic [PW-1:0] w_rd_ptr1;

    assign w_rd_ptr1 = r_rd_ptr + PW'(1);
    assign o_head0   = r_mem[r_rd_ptr];
    assign o_head1   = r_mem[w_rd_ptr1];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so the adds wrap naturally.
            r_rd_ptr <= r_rd_ptr + PW'(i_pop_n);
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            r_count <= r_count + (PW+1)'(i_push) - (PW+1)'(i_pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/wb_commit.sv
// Dual-issue writeback/commit: registers pipe results onto write ports 1/2 and
// backfills unused ports from the long-latency FIFO. Option: WB_COMMIT_TRACE_EN.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int LQ_DEPTH   = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic       clk,
    input  logic       aresetn,
    wb_commit_if.slave bus
);
    localparam int CW = $clog2(LQ_DEPTH) + 1;
    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_nxt;
    lq_entry_t         w_head0;
    lq_entry_t         w_head1;
    lq_entry_t         w_push_data;
    logic              w_lq_ready;
    logic              w_push;
    logic              w_use0;
    logic              w_use1;
    logic [1:0]        w_pop_n;
    logic              w_we1;
    logic [ADDR_W-1:0] w_waddr1;
    logic [DATA_W-1:0] w_wdata1;
    logic              w_we2;
    logic [ADDR_W-1:0] w_waddr2;
    logic [DATA_W-1:0] w_wdata2;

    logic              r_we1;
    logic [ADDR_W-1:0] r_waddr1;
    logic [DATA_W-1:0] r_wdata1;
    logic              r_we2;
    logic [ADDR_W-1:0] r_waddr2;
    logic [DATA_W-1:0] r_wdata2;
    logic              r_stall;
    lq_state_e         r_state;
    lq_state_e         w_state_nxt;
    logic [SW-1:0]     r_starve;
    logic [SW-1:0]     w_starve_nxt;

    assign w_use0      = bus.ex0_valid & bus.ex0_we & (bus.ex0_waddr != '0) & ~bus.flush;
    assign w_use1      = bus.ex1_valid & bus.ex1_we & (bus.ex1_waddr != '0) & ~bus.flush;
    assign w_lq_ready  = (w_count < CW'(LQ_DEPTH));
    assign w_push      = bus.lq_valid & w_lq_ready;
    assign w_push_data = '{waddr: bus.lq_waddr, wdata: bus.lq_wdata};
    assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop_n);

    wb_lq_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk         (clk),
        .aresetn     (aresetn),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop_n     (w_pop_n),
        .o_head0     (w_head0),
        .o_head1     (w_head1),
        .o_count     (w_count)
    );

    // Pipe slots own their ports; the FIFO only sees what is left over, oldest first.
    always_comb begin
        w_we1    = 1'b0;
        w_waddr1 = '0;
        w_wdata1 = '0;
        w_we2    = 1'b0;
        w_waddr2 = '0;
        w_wdata2 = '0;
        w_pop_n  = 2'd0;
        if (w_use0) begin
            w_we1    = 1'b1;
            w_waddr1 = bus.ex0_waddr;
            w_wdata1 = bus.ex0_wdata;
        end else if (w_count != '0) begin
            w_we1                = 1'b1;
            {w_waddr1, w_wdata1} = w_head0;
            w_pop_n              = 2'd1;
        end
        if (w_use1) begin
            w_we2    = 1'b1;
            w_waddr2 = bus.ex1_waddr;
            w_wdata2 = bus.ex1_wdata;
        end else if (w_count > CW'(w_pop_n)) begin
            w_we2                = 1'b1;
            {w_waddr2, w_wdata2} = (w_pop_n == 2'd1) ? w_head1 : w_head0;
            w_pop_n              = w_pop_n + 2'd1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        unique case (r_state)
            ST_IDLE: begin
                if (w_push) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_pop_n != 2'd0) begin
                    w_starve_nxt = '0;
                end else if (r_starve == SW'(STARVE_MAX - 1)) begin
                    w_state_nxt = ST_STARVE;
                end else begin
                    w_starve_nxt = r_starve + SW'(1);
                end
            end
            ST_STARVE: begin
                if (w_pop_n != 2'd0) begin
                    w_state_nxt  = ST_DRAIN;
                    w_starve_nxt = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_count_nxt == '0) begin
            w_state_nxt  = ST_IDLE;
            w_starve_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state  <= ST_IDLE;
            r_starve <= '0;
            r_stall  <= 1'b0;
            r_we1    <= 1'b0;
            r_waddr1 <= '0;
            r_wdata1 <= '0;
            r_we2    <= 1'b0;
            r_waddr2 <= '0;
            r_wdata2 <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            // Stall request trails the STARVE state by one cycle on both entry and exit.
            r_stall  <= (r_state == ST_STARVE);
            r_we1    <= w_we1;
            r_waddr1 <= w_waddr1;
            r_wdata1 <= w_wdata1;
            r_we2    <= w_we2;
            r_waddr2 <= w_waddr2;
            r_wdata2 <= w_wdata2;
        end
    end

    assign bus.lq_ready     = w_lq_ready;
    assign bus.lq_stall_req = r_stall;
    assign bus.we1          = r_we1;
    assign bus.waddr1       = r_waddr1;
    assign bus.wdata1       = r_wdata1;
    assign bus.we2          = r_we2;
    assign bus.waddr2       = r_waddr2;
    assign bus.wdata2       = r_wdata2;

`ifdef WB_COMMIT_TRACE_EN
    logic        r_cmt1_valid;
    logic [31:0] r_cmt1_pc;
    logic [31:0] r_cmt1_inst;
    logic        r_cmt2_valid;
    logic [31:0] r_cmt2_pc;
    logic [31:0] r_cmt2_inst;

    // FIFO drains commit with pc/inst of zero; only pipe slots carry real trace data.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_cmt1_valid <= 1'b0;
            r_cmt1_pc    <= '0;
            r_cmt1_inst  <= '0;
            r_cmt2_valid <= 1'b0;
            r_cmt2_pc    <= '0;
            r_cmt2_inst  <= '0;
        end else begin
            r_cmt1_valid <= w_we1;
            r_cmt1_pc    <= w_use0 ? bus.ex0_pc   : '0;
            r_cmt1_inst  <= w_use0 ? bus.ex0_inst : '0;
            r_cmt2_valid <= w_we2;
            r_cmt2_pc    <= w_use1 ? bus.ex1_pc   : '0;
            r_cmt2_inst  <= w_use1 ? bus.ex1_inst : '0;
        end
    end

    assign bus.cmt1_valid = r_cmt1_valid;
    assign bus.cmt1_pc    = r_cmt1_pc;
    assign bus.cmt1_inst  = r_cmt1_inst;
    assign bus.cmt2_valid = r_cmt2_valid;
    assign bus.cmt2_pc    = r_cmt2_pc;
    assign bus.cmt2_inst  = r_cmt2_inst;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: vector table, directed multi-cycle sequences and random
// traffic, all compared against a queue-based model of the commit rules.
module tb_wb_commit;
    import wb_commit_pkg::*;

    localparam int LQ_DEPTH   = 4;
    localparam int STARVE_MAX = 8;

    typedef struct packed {
        logic f; logic v0; logic w0; logic [4:0] a0; logic [31:0] d0;
        logic v1; logic w1; logic [4:0] a1; logic [31:0] d1;
        logic lv; logic [4:0] la; logic [31:0] ld;
    } in_t;

    typedef struct packed {
        logic we1; logic [4:0] a1; logic [31:0] d1;
        logic we2; logic [4:0] a2; logic [31:0] d2;
        logic rdy; logic stall;
    } out_t;

    typedef struct packed { in_t i; out_t o; } vec_t;
    typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;

    logic clk = 1'b0;
    logic aresetn;
    always #5 clk = ~clk;

    wb_commit_if bus();

    wb_commit #(.LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    ent_t q[$];
    bit   m_starving;
    int   m_cnt;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic in_t mk(logic v0, logic v1, logic lv, logic [4:0] la, logic [31:0] ld);
        in_t r;
        r = '{f: 1'b0, v0: v0, w0: 1'b1, a0: 5'd1, d0: 32'hC0DE_0001,
              v1: v1, w1: 1'b1, a1: 5'd2, d1: 32'hC0DE_0002,
              lv: lv, la: la, ld: ld};
        return r;
    endfunction

    function automatic vec_t tv(logic f, logic v0, logic w0, logic [4:0] a0, logic [31:0] d0,
                                logic v1, logic w1, logic [4:0] a1, logic [31:0] d1,
                                logic e1, logic [4:0] ea1, logic [31:0] ed1,
                                logic e2, logic [4:0] ea2, logic [31:0] ed2);
        vec_t r;
        r.i = '{f: f, v0: v0, w0: w0, a0: a0, d0: d0, v1: v1, w1: w1, a1: a1, d1: d1,
                lv: 1'b0, la: 5'd0, ld: 32'd0};
        r.o = '{we1: e1, a1: ea1, d1: ed1, we2: e2, a2: ea2, d2: ed2, rdy: 1'b1, stall: 1'b0};
        return r;
    endfunction

    task automatic drive(input in_t i);
        bus.flush     = i.f;
        bus.ex0_valid = i.v0; bus.ex0_we = i.w0; bus.ex0_waddr = i.a0; bus.ex0_wdata = i.d0;
        bus.ex1_valid = i.v1; bus.ex1_we = i.w1; bus.ex1_waddr = i.a1; bus.ex1_wdata = i.d1;
        bus.lq_valid  = i.lv; bus.lq_waddr = i.la; bus.lq_wdata = i.ld;
    endtask

    // One clock: model predicts the registered outputs, DUT is compared after the edge.
    task automatic step(input in_t i, output out_t e);
        bit   u0, u1, popped;
        int   n;
        ent_t h;
        drive(i);
        u0 = i.v0 && i.w0 && (i.a0 != 5'd0) && !i.f;
        u1 = i.v1 && i.w1 && (i.a1 != 5'd0) && !i.f;
        n = q.size();
        popped = 1'b0;
        e = '0;
        if (u0) begin e.we1 = 1'b1; e.a1 = i.a0; e.d1 = i.d0; end
        else if (q.size() > 0) begin
            h = q.pop_front(); e.we1 = 1'b1; e.a1 = h.a; e.d1 = h.d; popped = 1'b1;
        end
        if (u1) begin e.we2 = 1'b1; e.a2 = i.a1; e.d2 = i.d1; end
        else if (q.size() > 0) begin
            h = q.pop_front(); e.we2 = 1'b1; e.a2 = h.a; e.d2 = h.d; popped = 1'b1;
        end
        if (i.lv && n < LQ_DEPTH) q.push_back('{a: i.la, d: i.ld});
        e.rdy   = (q.size() < LQ_DEPTH);
        e.stall = m_starving;
        if (n == 0 || popped || q.size() == 0) begin
            m_starving = 1'b0; m_cnt = 0;
        end else if (!m_starving) begin
            if (m_cnt == STARVE_MAX - 1) m_starving = 1'b1;
            else m_cnt++;
        end
        @(posedge clk); #1;
        chk("model_we1",    32'(bus.we1),          32'(e.we1));
        chk("model_waddr1", 32'(bus.waddr1),       32'(e.a1));
        chk("model_wdata1", bus.wdata1,            e.d1);
        chk("model_we2",    32'(bus.we2),          32'(e.we2));
        chk("model_waddr2", 32'(bus.waddr2),       32'(e.a2));
        chk("model_wdata2", bus.wdata2,            e.d2);
        chk("model_ready",  32'(bus.lq_ready),     32'(e.rdy));
        chk("model_stall",  32'(bus.lq_stall_req), 32'(e.stall));
    endtask

    task automatic do_reset();
        drive('0);
        aresetn = 1'b0;
        @(posedge clk); #1;
        q.delete(); m_starving = 1'b0; m_cnt = 0;
        chk("rst_we1",    32'(bus.we1),          32'd0);
        chk("rst_waddr1", 32'(bus.waddr1),       32'd0);
        chk("rst_wdata1", bus.wdata1,            32'd0);
        chk("rst_we2",    32'(bus.we2),          32'd0);
        chk("rst_waddr2", 32'(bus.waddr2),       32'd0);
        chk("rst_wdata2", bus.wdata2,            32'd0);
        chk("rst_ready",  32'(bus.lq_ready),     32'd1);
        chk("rst_stall",  32'(bus.lq_stall_req), 32'd0);
        aresetn = 1'b1;
    endtask

    vec_t tbl[7];
    out_t e;
    in_t  x;
    int   busy_pct;

    initial begin
`ifdef WB_COMMIT_TRACE_EN
        bus.ex0_pc = 32'h1000; bus.ex0_inst = 32'h13;
        bus.ex1_pc = 32'h1004; bus.ex1_inst = 32'h13;
`endif
        aresetn = 1'b1;
        tbl[0] = tv(1'b0, 1'b1,1'b1,5'd3,32'h11,       1'b1,1'b1,5'd4,32'h22,
                    1'b1,5'd3,32'h11,        1'b1,5'd4,32'h22);
        tbl[1] = tv(1'b0, 1'b1,1'b1,5'd0,32'h33,       1'b1,1'b1,5'd5,32'h44,
                    1'b0,5'd0,32'h0,         1'b1,5'd5,32'h44);
        tbl[2] = tv(1'b0, 1'b1,1'b0,5'd6,32'h55,       1'b0,1'b1,5'd7,32'h66,
                    1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0);
        tbl[3] = tv(1'b1, 1'b1,1'b1,5'd8,32'h77,       1'b1,1'b1,5'd9,32'h88,
                    1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0);
        tbl[4] = tv(1'b0, 1'b0,1'b0,5'd0,32'h0,        1'b1,1'b1,5'd31,32'hFFFF_FFFF,
                    1'b0,5'd0,32'h0,         1'b1,5'd31,32'hFFFF_FFFF);
        tbl[5] = tv(1'b0, 1'b1,1'b1,5'd1,32'hDEAD_BEEF, 1'b1,1'b1,5'd0,32'h1,
                    1'b1,5'd1,32'hDEAD_BEEF, 1'b0,5'd0,32'h0);
        tbl[6] = tv(1'b0, 1'b1,1'b1,5'd9,32'hA,        1'b1,1'b1,5'd9,32'hB,
                    1'b1,5'd9,32'hA,         1'b1,5'd9,32'hB);

        do_reset();
        for (int k = 0; k < 7; k++) begin
            step(tbl[k].i, e);
            chk("tbl_we1",    32'(bus.we1),    32'(tbl[k].o.we1));
            chk("tbl_waddr1", 32'(bus.waddr1), 32'(tbl[k].o.a1));
            chk("tbl_wdata1", bus.wdata1,      tbl[k].o.d1);
            chk("tbl_we2",    32'(bus.we2),    32'(tbl[k].o.we2));
            chk("tbl_waddr2", 32'(bus.waddr2), 32'(tbl[k].o.a2));
            chk("tbl_wdata2", bus.wdata2,      tbl[k].o.d2);
        end

        // Starvation: both slots write every cycle while r7 waits in the FIFO.
        step(mk(1'b1, 1'b1, 1'b1, 5'd7, 32'hAB), e);
        for (int k = 1; k <= STARVE_MAX + 1; k++) begin
            step(mk(1'b1, 1'b1, 1'b0, 5'd0, 32'd0), e);
            if (k == STARVE_MAX) chk("starve_not_yet", 32'(bus.lq_stall_req), 32'd0);
        end
        chk("starve_stall", 32'(bus.lq_stall_req), 32'd1);
        step(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'd0), e);
        chk("starve_we1",    32'(bus.we1),          32'd1);
        chk("starve_waddr1", 32'(bus.waddr1),       32'd7);
        chk("starve_wdata1", bus.wdata1,            32'hAB);
        chk("starve_hold",   32'(bus.lq_stall_req), 32'd1);
        step(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'd0), e);
        chk("starve_drop",   32'(bus.lq_stall_req), 32'd0);
        chk("starve_idle",   32'(bus.we1),          32'd0);

        // Two queued entries drain together into both free ports.
        step(mk(1'b1, 1'b1, 1'b1, 5'd5, 32'd1), e);
        step(mk(1'b1, 1'b1, 1'b1, 5'd6, 32'd2), e);
        step(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'd0), e);
        chk("dual_waddr1", 32'(bus.waddr1), 32'd5);
        chk("dual_wdata1", bus.wdata1,      32'd1);
        chk("dual_waddr2", 32'(bus.waddr2), 32'd6);
        chk("dual_wdata2", bus.wdata2,      32'd2);
        step(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'd0), e);
        chk("dual_empty", 32'(bus.we1) + 32'(bus.we2), 32'd0);

        // Full FIFO: push while full is dropped; push+pop at 3 keeps 3.
        for (int k = 0; k < 4; k++)
            step(mk(1'b1, 1'b1, 1'b1, 5'(10 + k), 32'h100 + 32'(k)), e);
        chk("full_ready", 32'(bus.lq_ready), 32'd0);
        step(mk(1'b0, 1'b1, 1'b1, 5'd14, 32'h114), e);
        chk("full_pop_addr", 32'(bus.waddr1),   32'd10);
        chk("full_drop_rdy", 32'(bus.lq_ready), 32'd1);
        step(mk(1'b0, 1'b1, 1'b1, 5'd15, 32'h115), e);
        chk("pp_addr",  32'(bus.waddr1),   32'd11);
        chk("pp_ready", 32'(bus.lq_ready), 32'd1);
        step(mk(1'b1, 1'b1, 1'b1, 5'd16, 32'h116), e);
        chk("refill_ready", 32'(bus.lq_ready), 32'd0);
        step(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'd0), e);
        chk("order_a1", 32'(bus.waddr1), 32'd12);
        chk("order_a2", 32'(bus.waddr2), 32'd13);
        step(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'd0), e);
        chk("order_a3", 32'(bus.waddr1), 32'd15);
        chk("order_d3", bus.wdata1,      32'h115);
        chk("order_a4", 32'(bus.waddr2), 32'd16);
        step(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'd0), e);
        chk("order_done", 32'(bus.we1) + 32'(bus.we2), 32'd0);

        // Flush kills both slots but the queued entry still drains.
        step(mk(1'b1, 1'b1, 1'b1, 5'd8, 32'h55), e);
        x = mk(1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        x.f = 1'b1;
        step(x, e);
        chk("flush_we1",    32'(bus.we1),    32'd1);
        chk("flush_waddr1", 32'(bus.waddr1), 32'd8);
        chk("flush_we2",    32'(bus.we2),    32'd0);

        // Reset with three entries queued discards them.
        for (int k = 0; k < 3; k++)
            step(mk(1'b1, 1'b1, 1'b1, 5'(20 + k), 32'h200 + 32'(k)), e);
        do_reset();
        step(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'd0), e);
        chk("post_rst_we1", 32'(bus.we1), 32'd0);
        chk("post_rst_we2", 32'(bus.we2), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            busy_pct = ((c / 64) % 2 == 1) ? 96 : 45;
            x.f  = ($urandom_range(0, 15) == 0);
            x.v0 = ($urandom_range(0, 99) < busy_pct);
            x.w0 = ($urandom_range(0, 7) != 0);
            x.a0 = 5'($urandom);
            x.d0 = $urandom;
            x.v1 = ($urandom_range(0, 99) < busy_pct);
            x.w1 = ($urandom_range(0, 7) != 0);
            x.a1 = 5'($urandom);
            x.d1 = $urandom;
            x.lv = ($urandom_range(0, 2) == 0);
            x.la = 5'($urandom);
            x.ld = $urandom;
            if ($urandom_range(0, 499) == 0) do_reset();
            else step(x, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
